// File: rtl/fetch_pkg.sv
// Shared widths, state encoding and queue entry layout for the instruction fetch front end.
package fetch_pkg;
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 8;
  localparam logic [INSTR_W-1:0] HALT_OP_DEF = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/instr_fetch_if.sv
// Fetch front-end bus: IMEM read port, redirect input and the decode-side valid/ready handshake.
interface instr_fetch_if;
  import fetch_pkg::*;

  logic               fetch_en;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr_data;
  logic [ADDR_W-1:0]  instr_pc;
  logic               halted;

  modport master (
    input  fetch_en, imem_instr, redirect_valid, redirect_pc, instr_ready,
    output imem_addr, instr_valid, instr_data, instr_pc, halted
  );

  modport slave (
    output fetch_en, imem_instr, redirect_valid, redirect_pc, instr_ready,
    input  imem_addr, instr_valid, instr_data, instr_pc, halted
  );
endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {pc, instr} pairs; flush wins over push and pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         empty,
  output logic         full,
  output logic [PW:0]  count
);
  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // Full queue may still accept a word when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/instr_fetch.sv
// Fetch front end: owns the PC, reads IMEM, queues {pc, instr} for decode, handles redirect and HALT.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int                 MEM_DEPTH = 32,
  parameter int                 Q_DEPTH   = 2,
  parameter logic [INSTR_W-1:0] HALT_OP   = HALT_OP_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);
  localparam int                CW      = $clog2(Q_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] PC_MASK = ADDR_W'(MEM_DEPTH - 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  logic         q_empty, q_full, push, pop;
  logic [CW-1:0] q_count;
  fetch_entry_t q_din, q_dout;

  // A redirect turns the same-cycle pop into a discard, not a transfer.
  assign pop   = ~q_empty & bus.instr_ready & ~bus.redirect_valid;
  assign push  = (state_q == FETCH) & bus.fetch_en & ~bus.redirect_valid & (~q_full | pop);
  assign q_din = '{pc: pc_q, instr: bus.imem_instr};

  fetch_queue #(.DEPTH(Q_DEPTH)) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_valid),
    .din   (q_din),
    .dout  (q_dout),
    .empty (q_empty),
    .full  (q_full),
    .count (q_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (bus.redirect_valid) begin
      pc_d    = bus.redirect_pc & PC_MASK;
      state_d = bus.fetch_en ? FETCH : IDLE;
    end else begin
      if (push) pc_d = (pc_q + 1'b1) & PC_MASK;
      case (state_q)
        IDLE:    if (bus.fetch_en) state_d = FETCH;
        FETCH: begin
          if (!bus.fetch_en)                          state_d = IDLE;
          else if (push && bus.imem_instr == HALT_OP) state_d = HALT;
        end
        HALT:    state_d = HALT;
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = (q_count != '0);
  assign bus.instr_data  = q_dout.instr;
  assign bus.instr_pc    = q_dout.pc;
  assign bus.halted      = (state_q == HALT);
endmodule
